memory_unit: RTL and testbench

MEMORY_UNIT -- requirements
Module: memory_unit

---
 rtl/memory_unit_pkg.sv | 57 +++++
 rtl/memory_unit_csr_counters.sv | 47 ++++
 rtl/memory_unit.sv | 140 ++++++++++++++
 tb/tb_memory_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_unit_pkg
// Description : Shared constants for the memory stage: CSR counter addresses,
//               load/store funct3 encodings, the canonical NOP and the
//               load-data extraction helper.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_unit_pkg;

    // ADD x0,x0,x0
    localparam logic [31:0] c_NOP = 32'h0000_0033;

    // Read-only counter CSRs
    localparam logic [11:0] c_CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] c_CSR_TIME     = 12'hC01;
    localparam logic [11:0] c_CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] c_CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] c_CSR_TIMEH    = 12'hC81;
    localparam logic [11:0] c_CSR_INSTRETH = 12'hC82;

    // Load/store width encodings
    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    // Pick the byte/half addressed by the low address bits and extend it.
    // Halves use only off[1], so misaligned halves silently truncate.
    function automatic logic [31:0] f_load_extract(
        input logic [31:0] mdata,
        input logic [1:0]  off,
        input logic [2:0]  f3
    );
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        logic [31:0] v_res;
        case (off)
            2'd0:    v_byte = mdata[7:0];
            2'd1:    v_byte = mdata[15:8];
            2'd2:    v_byte = mdata[23:16];
            default: v_byte = mdata[31:24];
        endcase
        v_half = off[1] ? mdata[31:16] : mdata[15:0];
        case (f3)
            c_F3_B:  v_res = {{24{v_byte[7]}}, v_byte};
            c_F3_H:  v_res = {{16{v_half[15]}}, v_half};
            c_F3_BU: v_res = {24'd0, v_byte};
            c_F3_HU: v_res = {16'd0, v_half};
            default: v_res = mdata;
        endcase
        return v_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_unit_csr_counters.sv
`default_nettype none
// ============================================================================
// Module      : csr_counters
// Description : 64-bit cycle and instret counters with the read-only CSR
//               read mux. Reads return the value before this edge's update.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counters
    import memory_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        i_retire,
    input  logic [11:0] i_csr_id,
    output logic [31:0] o_rdata
);

    logic [63:0] r_cycle;
    logic [63:0] r_instret;

    // Free-running cycle counter and retirement counter, both wrap naturally
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cycle   <= 64'd0;
            r_instret <= 64'd0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (i_retire) begin
                r_instret <= r_instret + 64'd1;
            end
        end
    end

    // CSR read mux; unknown addresses read as zero
    always_comb begin
        o_rdata = 32'd0;
        case (i_csr_id)
            c_CSR_CYCLE, c_CSR_TIME:   o_rdata = r_cycle[31:0];
            c_CSR_CYCLEH, c_CSR_TIMEH: o_rdata = r_cycle[63:32];
            c_CSR_INSTRET:             o_rdata = r_instret[31:0];
            c_CSR_INSTRETH:            o_rdata = r_instret[63:32];
            default:                   o_rdata = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memory_unit.sv
`default_nettype none
// ============================================================================
// Module      : memory_unit
// Description : Pipeline memory stage. Forms the data-memory store strobe,
//               extracts load data, muxes the writeback value and holds the
//               MW pipeline register with stall/flush handling.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_unit
    import memory_unit_pkg::*;
#(
    parameter bit RETIRE_NOP = 1'b0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        M_stall_i,
    input  logic        W_flush_i,
    input  logic [31:0] EM_PC_i,
    input  logic [31:0] EM_instr_i,
    input  logic        EM_nop_i,
    input  logic        EM_isLoad_i,
    input  logic        EM_isStore_i,
    input  logic        EM_isCSR_i,
    input  logic [5:0]  EM_rdId_i,
    input  logic [11:0] EM_csrId_i,
    input  logic [31:0] EM_rs2_i,
    input  logic [2:0]  EM_funct3_i,
    input  logic [31:0] EM_Eresult_i,
    input  logic [31:0] EM_addr_i,
    input  logic [31:0] EM_Mdata_i,
    input  logic        EM_wbEnable_i,
    output logic [31:0] DMemWAddr_o,
    output logic [31:0] DMemWData_o,
    output logic [3:0]  DMemWMask_o,
    output logic [31:0] MW_PC_o,
    output logic [31:0] MW_instr_o,
    output logic        MW_nop_o,
    output logic [5:0]  MW_rdId_o,
    output logic [31:0] MW_wbData_o,
    output logic        MW_wbEnable_o
);

    logic        w_retire;
    logic [31:0] w_csr_rdata;
    logic [31:0] w_wb_data;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_nop;
    logic [5:0]  r_rd;
    logic [31:0] r_wb;
    logic        r_we;

    // A flushed or stalled slot never counts as retired
    assign w_retire = !M_stall_i && !W_flush_i && (!EM_nop_i || RETIRE_NOP);

    csr_counters u_csr (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .i_retire (w_retire),
        .i_csr_id (EM_csrId_i),
        .o_rdata  (w_csr_rdata)
    );

    // Writeback source priority: load, then CSR, then execute result
    always_comb begin
        w_wb_data = EM_Eresult_i;
        if (EM_isLoad_i) begin
            w_wb_data = f_load_extract(EM_Mdata_i, EM_addr_i[1:0], EM_funct3_i);
        end else if (EM_isCSR_i) begin
            w_wb_data = w_csr_rdata;
        end
    end

    // Store lane strobe and replicated write data; strobe gated off by stall/reset
    always_comb begin
        w_mask  = 4'b0000;
        w_wdata = EM_rs2_i;
        case (EM_funct3_i)
            c_F3_B: begin
                w_mask  = 4'b0001 << EM_addr_i[1:0];
                w_wdata = {4{EM_rs2_i[7:0]}};
            end
            c_F3_H: begin
                w_mask  = EM_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{EM_rs2_i[15:0]}};
            end
            c_F3_W: begin
                w_mask  = 4'b1111;
            end
            default: begin
                w_mask  = 4'b0000;
            end
        endcase
        if (!EM_isStore_i || M_stall_i || reset_i) begin
            w_mask = 4'b0000;
        end
    end

    assign DMemWAddr_o = {EM_addr_i[31:2], 2'b00};
    assign DMemWData_o = w_wdata;
    assign DMemWMask_o = w_mask;

    // MW pipeline register: flush inserts a bubble even when stalled
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_pc    <= 32'd0;
            r_instr <= c_NOP;
            r_nop   <= 1'b1;
            r_rd    <= 6'd0;
            r_wb    <= 32'd0;
            r_we    <= 1'b0;
        end else if (W_flush_i) begin
            r_pc    <= 32'd0;
            r_instr <= c_NOP;
            r_nop   <= 1'b1;
            r_rd    <= 6'd0;
            r_wb    <= 32'd0;
            r_we    <= 1'b0;
        end else if (!M_stall_i) begin
            r_pc    <= EM_PC_i;
            r_instr <= EM_instr_i;
            r_nop   <= EM_nop_i;
            r_rd    <= EM_rdId_i;
            r_wb    <= w_wb_data;
            r_we    <= EM_wbEnable_i && (EM_rdId_i != 6'd0);
        end
    end

    assign MW_PC_o       = r_pc;
    assign MW_instr_o    = r_instr;
    assign MW_nop_o      = r_nop;
    assign MW_rdId_o     = r_rd;
    assign MW_wbData_o   = r_wb;
    assign MW_wbEnable_o = r_we;

endmodule
`default_nettype wire

// File: tb/tb_memory_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_unit
// Description : Self-checking bench for memory_unit: behavioural model of
//               the MW register and counters, directed corner cases and a
//               randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_unit;

    localparam logic [31:0] NOP_I = 32'h0000_0033;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        stall, flush;
    logic [31:0] pc, instr;
    logic        nop, is_ld, is_st, is_csr;
    logic [5:0]  rd;
    logic [11:0] csr_id;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic [31:0] eres, addr, mdata;
    logic        wbe;
    logic [31:0] waddr_o, wdata_o;
    logic [3:0]  wmask_o;
    logic [31:0] mw_pc, mw_instr, mw_wb;
    logic        mw_nop, mw_we;
    logic [5:0]  mw_rd;

    memory_unit dut (
        .clk_i(clk), .reset_i(reset_i), .M_stall_i(stall), .W_flush_i(flush),
        .EM_PC_i(pc), .EM_instr_i(instr), .EM_nop_i(nop), .EM_isLoad_i(is_ld),
        .EM_isStore_i(is_st), .EM_isCSR_i(is_csr), .EM_rdId_i(rd),
        .EM_csrId_i(csr_id), .EM_rs2_i(rs2), .EM_funct3_i(f3),
        .EM_Eresult_i(eres), .EM_addr_i(addr), .EM_Mdata_i(mdata),
        .EM_wbEnable_i(wbe), .DMemWAddr_o(waddr_o), .DMemWData_o(wdata_o),
        .DMemWMask_o(wmask_o), .MW_PC_o(mw_pc), .MW_instr_o(mw_instr),
        .MW_nop_o(mw_nop), .MW_rdId_o(mw_rd), .MW_wbData_o(mw_wb),
        .MW_wbEnable_o(mw_we)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    logic chk_en = 1'b0;

    // Model state
    logic [31:0] m_pc, m_instr, m_wb;
    logic        m_nop, m_we, m_dc;
    logic [5:0]  m_rd;
    logic [63:0] m_cycle, m_instret;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] exp_csr(input logic [11:0] id);
        case (id)
            12'hC00, 12'hC01: return m_cycle[31:0];
            12'hC80, 12'hC81: return m_cycle[63:32];
            12'hC02:          return m_instret[31:0];
            12'hC82:          return m_instret[63:32];
            default:          return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_load();
        logic [31:0] b, h;
        b = mdata >> (8 * addr[1:0]);
        h = mdata >> (16 * addr[1]);
        case (f3)
            3'd0:    return {{24{b[7]}}, b[7:0]};
            3'd1:    return {{16{h[15]}}, h[15:0]};
            3'd4:    return {24'd0, b[7:0]};
            3'd5:    return {16'd0, h[15:0]};
            default: return mdata;
        endcase
    endfunction

    function automatic logic [3:0] exp_mask();
        if (!is_st || stall || reset_i) return 4'd0;
        case (f3)
            3'd0:    return 4'(1 << addr[1:0]);
            3'd1:    return addr[1] ? 4'b1100 : 4'b0011;
            3'd2:    return 4'b1111;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata();
        case (f3)
            3'd0:    return {4{rs2[7:0]}};
            3'd1:    return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

    // Advance the model across one rising edge
    task automatic model_edge();
        logic [31:0] v_wb;
        if (reset_i) begin
            m_pc = 0; m_instr = NOP_I; m_nop = 1; m_rd = 0; m_wb = 0; m_we = 0;
            m_dc = 0; m_cycle = 0; m_instret = 0;
        end else begin
            v_wb = is_ld ? exp_load() : (is_csr ? exp_csr(csr_id) : eres);
            if (!stall && !flush && !nop) m_instret = m_instret + 64'd1;
            m_cycle = m_cycle + 64'd1;
            if (flush) begin
                m_nop = 1; m_we = 0; m_instr = NOP_I; m_dc = 1;
            end else if (!stall) begin
                m_pc = pc; m_instr = instr; m_nop = nop; m_rd = rd; m_wb = v_wb;
                m_we = wbe && (rd != 6'd0); m_dc = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        stall = 0; flush = 0; pc = 0; instr = NOP_I; nop = 0; is_ld = 0;
        is_st = 0; is_csr = 0; rd = 0; csr_id = 0; rs2 = 0; f3 = 0; eres = 0;
        addr = 0; mdata = 0; wbe = 0;
    endtask

    task automatic csr_rd(input logic [11:0] id, input logic [31:0] p);
        idle(); is_csr = 1; csr_id = id; rd = 6'd7; wbe = 1; pc = p;
    endtask

    // Single compare process: checks outputs against the model mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("mask", wmask_o, exp_mask());
            check("waddr", waddr_o, {addr[31:2], 2'b00});
            if (is_st && (f3 <= 3'd2)) check("wdata", wdata_o, exp_wdata());
            check("mw_nop", mw_nop, m_nop);
            check("mw_we", mw_we, m_we);
            check("mw_instr", mw_instr, m_instr);
            if (!m_dc) begin
                check("mw_pc", mw_pc, m_pc);
                check("mw_rd", mw_rd, m_rd);
                check("mw_wb", mw_wb, m_wb);
            end
        end
    end

    initial begin
        logic [31:0] v1;
        int strobes;
        idle();
        reset_i = 1;
        tick(); tick();
        // Reset state
        check("rst_nop", mw_nop, 1'b1);
        check("rst_instr", mw_instr, NOP_I);
        check("rst_we", mw_we, 1'b0);
        check("rst_pc", mw_pc, 32'd0);
        check("rst_mask_st", wmask_o, 4'd0);
        reset_i = 0;
        chk_en = 1;
        tick();

        // SB lane select and replication
        idle(); is_st = 1; f3 = 3'd0; rs2 = 32'h0000_00A5; addr = 32'h0000_1003; pc = 32'h100;
        #1;
        check("sb_mask", wmask_o, 4'b1000);
        check("sb_data", wdata_o, 32'hA5A5_A5A5);
        check("sb_waddr", waddr_o, 32'h0000_1000);
        tick();

        // LH / LHU on upper half
        idle(); is_ld = 1; f3 = 3'd1; mdata = 32'h8001_7FFF; addr = 32'h0000_2002; rd = 6'd5; wbe = 1;
        tick();
        check("lh", mw_wb, 32'hFFFF_8001);
        f3 = 3'd5;
        tick();
        check("lhu", mw_wb, 32'h0000_8001);

        // Store held by stall for three cycles
        idle(); pc = 32'h100; tick();
        idle(); is_st = 1; f3 = 3'd0; rs2 = 32'h5A; addr = 32'h1003; pc = 32'h200; stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_mask", wmask_o, 4'd0);
            tick();
            check("stall_pc", mw_pc, 32'h100);
        end
        stall = 0;
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (wmask_o != 4'd0) strobes++;
            tick();
            idle();
        end
        check("strobe_cnt", strobes, 1);

        // Stall plus flush: bubble, no retirement
        csr_rd(12'hC02, 32'h300); tick();
        v1 = mw_wb;
        idle(); stall = 1; flush = 1; pc = 32'h304; rd = 6'd3; wbe = 1; tick();
        check("sf_nop", mw_nop, 1'b1);
        check("sf_we", mw_we, 1'b0);
        csr_rd(12'hC02, 32'h308); tick();
        check("sf_instret", mw_wb - v1, 32'd1);

        // Counter wrap
        csr_rd(12'hC80, 32'h400);
        force dut.u_csr.r_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.u_csr.r_cycle;
        m_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        check("wrap_hi_pre", mw_wb, 32'hFFFF_FFFF);
        tick();
        check("wrap_hi", mw_wb, 32'd0);
        csr_rd(12'hC00, 32'h408); tick();
        check("wrap_lo", mw_wb, 32'd1);

        // Asynchronous reset in the middle of a store
        chk_en = 0;
        idle(); is_st = 1; f3 = 3'd2; rs2 = 32'hDEAD_BEEF; addr = 32'h44; pc = 32'h500;
        #1;
        check("ar_pre_mask", wmask_o, 4'b1111);
        #1 reset_i = 1;
        #1;
        check("ar_mask", wmask_o, 4'd0);
        check("ar_nop", mw_nop, 1'b1);
        check("ar_instr", mw_instr, NOP_I);
        tick();
        reset_i = 0;
        chk_en = 1;
        csr_rd(12'hC00, 32'h600); tick();
        check("ar_cycle0", mw_wb, 32'd0);
        csr_rd(12'hC02, 32'h604); tick();
        check("ar_instret", mw_wb, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            stall  = ($urandom_range(0, 4) == 0);
            flush  = ($urandom_range(0, 9) == 0);
            nop    = ($urandom_range(0, 6) == 0);
            pc     = $urandom; instr = $urandom; eres = $urandom;
            addr   = $urandom; mdata = $urandom; rs2 = $urandom;
            rd     = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            wbe    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: ;
                1: begin is_ld = 1; f3 = 3'($urandom_range(0, 7)); end
                2: begin is_st = 1; f3 = 3'($urandom_range(0, 3)); end
                default: begin
                    is_csr = 1;
                    case ($urandom_range(0, 6))
                        0: csr_id = 12'hC00; 1: csr_id = 12'hC01; 2: csr_id = 12'hC02;
                        3: csr_id = 12'hC80; 4: csr_id = 12'hC81; 5: csr_id = 12'hC82;
                        default: csr_id = 12'($urandom);
                    endcase
                end
            endcase
            if ($urandom_range(0, 5) == 0) begin is_ld = 1; is_csr = 1; end
            tick();
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
